// File: rtl/avg_frame_tx.sv
// avg_frame_tx -- transmit sequencer for the averaged sensor frame.
//
// Captures a PAYLOAD_BYTES-byte frame when frame_valid strobes while idle.
// The frame is streamed most-significant byte first over a valid/ready
// handshake, followed by a two-byte CRC-16/USB trailer (low byte first).
// Frames that arrive while a transfer is in progress are dropped, and
// drop_count tracks them, saturating at 8'hFF.
//
// Ports:
//   clk, n_rst    clock (rising edge), asynchronous active-low reset
//   frame_in      averaged payload; byte 0 is frame_in[8P-1 -: 8]
//   frame_valid   one-cycle strobe that qualifies frame_in
//   tx_data       registered byte to the USB transmitter
//   tx_valid      registered valid for tx_data
//   tx_ready      transmitter accepts tx_data this cycle
//   busy          high from capture until the last CRC byte is accepted
//   done          one-cycle pulse after the last CRC byte is accepted
//   drop_count    saturating count of frames dropped while busy
module avg_frame_tx #(
    parameter int PAYLOAD_BYTES = 64
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [8*PAYLOAD_BYTES-1:0] frame_in,
    input  logic                       frame_valid,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 drop_count
);

    localparam int FW    = 8 * PAYLOAD_BYTES;
    localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND_DATA,
        SEND_CRC_LO,
        SEND_CRC_HI
    } state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     buf_q, buf_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       crc_q, crc_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              done_q, done_d;
    logic [7:0]        drop_q, drop_d;
    logic              accept;

    // Reflected CRC-16 (poly 0xA001), one full byte per call, LSB first.
    function automatic logic [15:0] crc16_usb_byte(input logic [15:0] crc,
                                                   input logic [7:0]  d);
        logic [15:0] c;
        c = crc ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return c;
    endfunction

    assign accept = tx_valid_q && tx_ready;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        crc_d      = crc_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        drop_d     = drop_q;

        case (state_q)
            IDLE: begin
                if (frame_valid) begin
                    // The buffer is kept pre-shifted so its top byte is always
                    // the next byte to present; byte 0 goes straight out.
                    tx_data_d  = frame_in[FW-1 -: 8];
                    buf_d      = frame_in << 8;
                    tx_valid_d = 1'b1;
                    idx_d      = '0;
                    crc_d      = 16'hFFFF;
                    state_d    = SEND_DATA;
                end
            end
            SEND_DATA: begin
                if (accept) begin
                    crc_d = crc16_usb_byte(crc_q, tx_data_q);
                    if (idx_q == LAST_IDX) begin
                        // Trailer low byte uses the CRC that includes this byte.
                        tx_data_d = ~crc_d[7:0];
                        state_d   = SEND_CRC_LO;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        tx_data_d = buf_q[FW-1 -: 8];
                        buf_d     = buf_q << 8;
                    end
                end
            end
            SEND_CRC_LO: begin
                if (accept) begin
                    tx_data_d = ~crc_q[15:8];
                    state_d   = SEND_CRC_HI;
                end
            end
            SEND_CRC_HI: begin
                if (accept) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A strobe on the final-accept cycle still sees a busy state and is dropped.
        if (frame_valid && (state_q != IDLE) && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            idx_q      <= '0;
            crc_q      <= 16'hFFFF;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            crc_q      <= crc_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_avg_frame_tx.sv
// Bench for avg_frame_tx: a 9-byte instance checked against the CRC-16/USB
// check string, and a default 64-byte instance driven through zero frames,
// random stalls, drops, mid-transfer reset and back-to-back frames.
module tb_avg_frame_tx;

    logic         clk = 1'b0;
    logic         n_rst = 1'b1;

    logic [511:0] frame = '0;
    logic         fv = 1'b0;
    logic         rdy = 1'b0;
    logic [7:0]   txd;
    logic         txv, busy, done;
    logic [7:0]   drop;

    logic [71:0]  frame9 = '0;
    logic         fv9 = 1'b0;
    logic         rdy9 = 1'b0;
    logic [7:0]   txd9;
    logic         txv9, busy9, done9;
    logic [7:0]   drop9;

    int n_chk = 0;
    int n_pass = 0;
    int vcnt = 0;
    int vcnt9 = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp9_q[$];
    logic       stall_p = 1'b0;
    logic [7:0] stall_d = 8'h00;

    avg_frame_tx u_dut (
        .clk(clk), .n_rst(n_rst), .frame_in(frame), .frame_valid(fv),
        .tx_data(txd), .tx_valid(txv), .tx_ready(rdy),
        .busy(busy), .done(done), .drop_count(drop)
    );

    avg_frame_tx #(.PAYLOAD_BYTES(9)) u_dut9 (
        .clk(clk), .n_rst(n_rst), .frame_in(frame9), .frame_valid(fv9),
        .tx_data(txd9), .tx_valid(txv9), .tx_ready(rdy9),
        .busy(busy9), .done(done9), .drop_count(drop9)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected bytes for a 64-byte frame: payload MSB first, then ~CRC low/high.
    task automatic push_frame(input logic [511:0] f);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int i = 0; i < 64; i++) begin
            b = f[511 - 8*i -: 8];
            exp_q.push_back(b);
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ b[k]) c = (c >> 1) ^ 16'hA001;
                else             c = c >> 1;
            end
        end
        exp_q.push_back(~c[7:0]);
        exp_q.push_back(~c[15:8]);
    endtask

    task automatic push9();
        logic [7:0] e [11];
        e = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        for (int i = 0; i < 11; i++) exp9_q.push_back(e[i]);
    endtask

    task automatic start(input logic [511:0] f);
        push_frame(f);
        frame = f;
        fv = 1'b1;
        tick();
        fv = 1'b0;
    endtask

    task automatic rand_frame(output logic [511:0] f);
        for (int i = 0; i < 16; i++) f[32*i +: 32] = $urandom();
    endtask

    task automatic wait_done(input bit d9, input bit rnd);
        int n;
        n = 0;
        do begin
            if (d9) rdy9 = 1'b1;
            else    rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end while (!(d9 ? done9 : done) && n < 5000);
        if (!(d9 ? done9 : done)) chk("done_timeout", 0, 1);
    endtask

    // Scoreboard for the 64-byte instance, sampled away from the active edge.
    always @(negedge clk) begin
        if (n_rst) begin
            if (stall_p) begin
                chk("stall_valid", {31'd0, txv}, 1);
                chk("stall_data", {24'd0, txd}, {24'd0, stall_d});
            end
            if (txv) vcnt++;
            if (txv && rdy) begin
                if (exp_q.size() == 0) chk("extra_byte", {24'd0, txd}, 32'hFFFF_FFFF);
                else chk("byte", {24'd0, txd}, {24'd0, exp_q.pop_front()});
            end
            stall_p = txv && !rdy;
            stall_d = txd;
        end else begin
            stall_p = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (n_rst) begin
            if (txv9) vcnt9++;
            if (txv9 && rdy9) begin
                if (exp9_q.size() == 0) chk("extra_byte9", {24'd0, txd9}, 32'hFFFF_FFFF);
                else chk("byte9", {24'd0, txd9}, {24'd0, exp9_q.pop_front()});
            end
        end
    end

    initial begin
        logic [511:0] f;
        #1 n_rst = 1'b0;
        #2;
        chk("rst_txd", {24'd0, txd}, 0);
        chk("rst_txv", {31'd0, txv}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_drop", {24'd0, drop}, 0);
        chk("rst_txv9", {31'd0, txv9}, 0);
        #9 n_rst = 1'b1;

        // 9-byte check string.
        push9();
        frame9 = 72'h313233343536373839;
        rdy9 = 1'b1;
        vcnt9 = 0;
        fv9 = 1'b1;
        tick();
        fv9 = 1'b0;
        chk("c9_busy", {31'd0, busy9}, 1);
        chk("c9_txv", {31'd0, txv9}, 1);
        wait_done(1, 0);
        chk("c9_vcnt", vcnt9, 11);
        chk("c9_done_busy", {31'd0, busy9}, 0);
        chk("c9_done_txv", {31'd0, txv9}, 0);
        tick();
        chk("c9_done_pulse", {31'd0, done9}, 0);

        // Strobe landing on the final-accept edge is dropped.
        push9();
        fv9 = 1'b1;
        tick();
        fv9 = 1'b0;
        repeat (10) tick();
        fv9 = 1'b1;
        tick();
        fv9 = 1'b0;
        chk("fa_done", {31'd0, done9}, 1);
        chk("fa_drop", {24'd0, drop9}, 1);
        tick();
        chk("fa_no_restart", {31'd0, busy9}, 0);
        chk("fa_txv", {31'd0, txv9}, 0);

        // All-zero 64-byte frame at full rate.
        rdy = 1'b1;
        vcnt = 0;
        start('0);
        wait_done(0, 0);
        chk("zero_vcnt", vcnt, 66);
        chk("zero_busy", {31'd0, busy}, 0);
        tick();
        chk("zero_done_pulse", {31'd0, done}, 0);

        // Random frame, random stalls, three drops mid-transfer.
        rand_frame(f);
        start(f);
        for (int i = 0; i < 5000 && !done; i++) begin
            rdy = 1'($urandom_range(0, 1));
            fv = (i == 5 || i == 20 || i == 40);
            frame = ~f;
            tick();
        end
        fv = 1'b0;
        chk("stall_done", {31'd0, done}, 1);
        chk("drop3", {24'd0, drop}, 3);

        // Saturation: 300 more drops while the transfer is held off.
        rand_frame(f);
        rdy = 1'b0;
        start(f);
        fv = 1'b1;
        for (int i = 0; i < 300; i++) begin
            frame = {16{$urandom()}};
            tick();
        end
        fv = 1'b0;
        chk("drop_sat", {24'd0, drop}, 32'hFF);
        wait_done(0, 0);

        // Reset after byte index 10 is accepted.
        rand_frame(f);
        rdy = 1'b1;
        start(f);
        repeat (11) tick();
        n_rst = 1'b0;
        #1;
        chk("mrst_txv", {31'd0, txv}, 0);
        chk("mrst_busy", {31'd0, busy}, 0);
        chk("mrst_drop", {24'd0, drop}, 0);
        exp_q.delete();
        #2 n_rst = 1'b1;
        tick();
        rand_frame(f);
        start(f);
        chk("mrst_first", {24'd0, txd}, {24'd0, f[511:504]});
        wait_done(0, 1);

        // New frame strobed in the done cycle.
        rand_frame(f);
        start(f);
        wait_done(0, 0);
        rand_frame(f);
        push_frame(f);
        frame = f;
        fv = 1'b1;
        tick();
        fv = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 1);
        chk("b2b_txv", {31'd0, txv}, 1);
        chk("b2b_drop", {24'd0, drop}, 0);
        chk("b2b_first", {24'd0, txd}, {24'd0, f[511:504]});
        wait_done(0, 0);

        tick();
        chk("exp_empty", exp_q.size(), 0);
        chk("exp9_empty", exp9_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/avg_frame_tx.md
# avg_frame_tx

Transmit-side sequencer for the averaged sensor frame. Captures the 64-byte averaged payload (16 channels × 32-bit averages) when the receive/average glue pulses its shift-out strobe. Streams the payload byte-by-byte to the USB transmit engine over a valid/ready handshake, then appends a CRC-16/USB trailer. Frames that arrive while a transfer is in progress are dropped and counted.

## Interface
- PAYLOAD_BYTES, 64, payload bytes per frame; must be ≥1.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- frame_in  in  8*PAYLOAD_BYTES  averaged payload; connects to averager outputs (bits [527:16] of the glue output bus at default size).
- frame_valid  in  1  one-cycle strobe: frame_in valid this cycle; driven by the glue shift-out strobe.
- tx_data  out  8  byte to USB transmitter.
- tx_valid  out  1  tx_data holds a valid byte.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- busy  out  1  high from capture until the final CRC byte is accepted.
- done  out  1  one-cycle pulse after the final CRC byte is accepted.
- drop_count  out  8  saturating count of frames dropped while busy.

## Operation
- States: IDLE, SEND_DATA, SEND_CRC_LO, SEND_CRC_HI.
- IDLE:
  - On frame_valid, register frame_in into a frame buffer, set byte index = 0, set crc = 16'hFFFF, and go to SEND_DATA.
  - With no frame_valid, stay in IDLE.
- SEND_DATA:
  - tx_valid = 1.
  - tx_data = buffer byte at the current index; index 0 is the most-significant byte, frame_in[8P-1:8P-8].
  - On accept (tx_valid && tx_ready), update crc with tx_data and increment the index.
  - On accepting index PAYLOAD_BYTES-1, go to SEND_CRC_LO.
- CRC algorithm: CRC-16/USB.
  - Reflected polynomial 16'hA001, LSB-first per byte, init 16'hFFFF.
  - The full 8-bit update happens in one cycle (combinational unroll).
- SEND_CRC_LO:
  - tx_data = ~crc[7:0].
  - On accept, go to SEND_CRC_HI.
- SEND_CRC_HI:
  - tx_data = ~crc[15:8].
  - On accept, go to IDLE and assert done on the next cycle.
- tx_data and tx_valid are registered. While tx_valid && !tx_ready, tx_data must not change.
- tx_valid never drops before acceptance; there is no abort path other than reset.
- frame_valid while busy: the frame is ignored and the buffer is unaffected. drop_count increments, saturating at 8'hFF and never wrapping.
- drop_count clears only on reset.
- CRC covers payload bytes only, never the trailer.

## Timing
- Reset values: tx_data 8'h00, tx_valid 0, busy 0, done 0, drop_count 0. Internal state: IDLE, index 0, crc 16'hFFFF.
- Reset asserted mid-transfer aborts immediately. tx_valid falls asynchronously and the partial frame is discarded.
- frame_valid sampled at edge N in IDLE → busy = 1 and tx_valid = 1 with byte 0 from edge N (visible in cycle N+1).
- Accept at edge M → next byte presented from edge M; back-to-back throughput is 1 byte/cycle with tx_ready held high.
- Minimum transfer: PAYLOAD_BYTES+2 cycles with tx_ready always high, from first tx_valid to final accept.
- Final CRC byte accepted at edge K:
  - busy = 0, tx_valid = 0 and done = 1 for the cycle after K.
  - done deasserts after one cycle.
- frame_valid in the done cycle is accepted as a new frame, giving back-to-back frames with one idle cycle between them.
- frame_valid in the same cycle as the final accept (still busy) is dropped and counted.
- tx_ready while tx_valid = 0 is ignored.

## Test plan
- PAYLOAD_BYTES = 9, frame_in = ASCII "123456789" (72'h313233343536373839), pulse frame_valid, tx_ready = 1 → bytes 31,32,…,39 then C8, B4 on consecutive cycles. Then done pulses once and busy falls.
- Default size, frame_in all 8'h00, tx_ready = 1 → 64 bytes 00 followed by two CRC bytes matching the reference-model CRC-16/USB. Transfer spans 66 cycles of tx_valid.
- Default size, tx_ready toggled pseudo-randomly (~50%):
  - tx_data stable on every stalled cycle.
  - Byte sequence identical to the unstalled run.
  - No byte is duplicated or skipped.
- Pulse frame_valid 3 times during a transfer → drop_count = 3 and the transmitted payload is the first frame only. Pulse 300 more times → drop_count holds at 8'hFF.
- Assert n_rst after byte 10 is accepted:
  - tx_valid = 0, busy = 0 and drop_count = 0 immediately.
  - A new frame after release transmits from byte 0 with fresh CRC init.
- frame_valid in the done cycle → second frame starts next cycle with busy high and drop_count unchanged.
